// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port data memory (IDLE -> ACCESS -> DONE).
// Optional macro DMEM_ARB_ROUND_ROBIN_EN: round-robin tie break instead of fixed port-0 priority.
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              core_stall,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        dbg_state,
    output logic              dbg_last_grant
);

    // Handshake: a requester holds req and its payload stable until a one-cycle
    // ack; it must drop or change req in the cycle after ack, otherwise the
    // still-high req is taken as a new request.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              last_grant;
    logic              grant_p1;
    logic              lat_we;
    logic              lat_port;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    // Winner selection, only meaningful while in IDLE with a request pending.
    always_comb begin
        grant_p1 = p1_req;
        if (p0_req && p1_req) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            grant_p1 = ~last_grant;
`else
            grant_p1 = 1'b0;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (p0_req || p1_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Transaction latch: everything after IDLE works from these copies.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_we     <= 1'b0;
            lat_port   <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            last_grant <= 1'b1;
        end else if (state == IDLE && (p0_req || p1_req)) begin
            lat_we     <= grant_p1 ? p1_we    : p0_we;
            lat_addr   <= grant_p1 ? p1_addr  : p0_addr;
            lat_wdata  <= grant_p1 ? p1_wdata : p0_wdata;
            lat_port   <= grant_p1;
            last_grant <= grant_p1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (state == ACCESS && !lat_we) begin
            if (lat_port) p1_rdata <= mem_rdata;
            else          p0_rdata <= mem_rdata;
        end
    end

    assign mem_addr       = lat_addr;
    assign mem_wdata      = lat_wdata;
    assign mem_we         = (state == ACCESS) &&  lat_we;
    assign mem_re         = (state == ACCESS) && !lat_we;
    assign p0_ack         = (state == DONE) && !lat_port;
    assign p1_ack         = (state == DONE) &&  lat_port;
    assign core_stall     = p0_req & ~p0_ack;
    assign busy           = (state != IDLE);
    assign dbg_state      = state;
    assign dbg_last_grant = last_grant;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

    logic        clock;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [31:0] p0_rdata, p1_rdata;
    logic        core_stall, busy, mem_we, mem_re;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  dbg_state;
    logic        dbg_last_grant;

    logic [31:0] mem [0:63];
    int          errors = 0;
    int          checks = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .core_stall(core_stall), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .dbg_state(dbg_state), .dbg_last_grant(dbg_last_grant)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: combinational read, write on the clock edge.
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clock) if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    endtask

    task automatic apply_reset();
        reset = 1;
        step(); step();
        reset = 0;
    endtask

    int stall_cnt;
    int ack_cyc;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[8'h20 >> 2] = 32'h12345678;
        mem[8'h30 >> 2] = 32'h0BADF00D;
        idle_inputs();
        apply_reset();

        // Port-0 store right after reset release.
        p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
        #1;
        check("rst_state", dbg_state, 0);
        check("rst_last_grant", dbg_last_grant, 1);
        check("rst_busy", busy, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_we_re", {mem_we, mem_re}, 0);
        check("rst_acks", {p0_ack, p1_ack}, 0);
        check("rst_rdata", {p0_rdata, p1_rdata}, 0);
        stall_cnt = int'(core_stall);
        step(); #1;
        check("st_mem_we", mem_we, 1);
        check("st_mem_re", mem_re, 0);
        check("st_mem_addr", mem_addr, 32'h10);
        check("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("st_busy", busy, 1);
        stall_cnt += int'(core_stall);
        step(); #1;
        check("st_p0_ack", p0_ack, 1);
        check("st_stall_ack", core_stall, 0);
        check("st_mem_we_done", mem_we, 0);
        stall_cnt += int'(core_stall);
        step(); idle_inputs(); #1;
        check("st_ack_pulse", p0_ack, 0);
        stall_cnt += int'(core_stall);
        check("st_stall_cycles", stall_cnt, 2);
        check("st_mem_written", mem[4], 32'hDEADBEEF);
        check("idle_keep_addr", mem_addr, 32'h10);

        // Port-1 load of the stored word.
        p1_req = 1; p1_we = 0; p1_addr = 32'h10;
        step(); #1;
        check("ld1_mem_re", mem_re, 1);
        check("ld1_mem_we", mem_we, 0);
        check("ld1_mem_addr", mem_addr, 32'h10);
        step(); #1;
        check("ld1_p1_ack", p1_ack, 1);
        check("ld1_p0_ack", p0_ack, 0);
        check("ld1_p1_rdata", p1_rdata, 32'hDEADBEEF);
        check("ld1_p0_rdata", p0_rdata, 0);
        step(); idle_inputs();

        // Port-0 load with the address changed during ACCESS.
        p0_req = 1; p0_we = 0; p0_addr = 32'h10;
        step(); p0_addr = 32'h20; #1;
        check("chg_mem_addr", mem_addr, 32'h10);
        step(); #1;
        check("chg_p0_ack", p0_ack, 1);
        check("chg_p0_rdata", p0_rdata, 32'hDEADBEEF);
        step(); idle_inputs();

        // Port-0 request held after ack: second access 3 cycles later.
        p0_req = 1; p0_we = 0; p0_addr = 32'h20;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("hold_ack_c%0d", c), p0_ack, (c == 2 || c == 5));
            step();
        end
        idle_inputs();
        check("hold_rdata", p0_rdata, 32'h12345678);
        step();

        // Both ports request continuously.
        apply_reset();
        p0_req = 1; p0_we = 0; p0_addr = 32'h20;
        p1_req = 1; p1_we = 0; p1_addr = 32'h30;
        ack_cyc = 0;
        for (int c = 0; c < 12; c++) begin
            logic e0, e1;
            #1;
            e0 = 0; e1 = 0;
            if (c % 3 == 2) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                e0 = ((c / 3) % 2 == 0);
                e1 = ((c / 3) % 2 == 1);
`else
                e0 = 1;
`endif
            end
            check($sformatf("both_p0_ack_c%0d", c), p0_ack, e0);
            check($sformatf("both_p1_ack_c%0d", c), p1_ack, e1);
            step();
        end
        idle_inputs();
        check("both_p0_rdata", p0_rdata, 32'h12345678);
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        check("both_p1_rdata", p1_rdata, 32'h0BADF00D);
`else
        check("both_p1_rdata", p1_rdata, 0);
`endif
        step();

        // Reset asserted during the ACCESS cycle of a port-0 store.
        p0_req = 1; p0_we = 1; p0_addr = 32'h30; p0_wdata = 32'hCAFEF00D;
        step(); #1;
        check("rsta_mem_we", mem_we, 1);
        reset = 1;
        step(); reset = 0; idle_inputs(); #1;
        check("rsta_state", dbg_state, 0);
        check("rsta_p0_ack", p0_ack, 0);
        check("rsta_mem_we", mem_we, 0);
        check("rsta_busy", busy, 0);
        check("rsta_mem_addr", mem_addr, 0);
        check("rsta_mem_wdata", mem_wdata, 0);
        check("rsta_rdata", {p0_rdata, p1_rdata}, 0);
        check("rsta_last_grant", dbg_last_grant, 1);
        step(); #1;
        check("rsta_no_ack_later", {p0_ack, p1_ack}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
